mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two requester ports plus the synchronous RAM port.
// slave = arbiter side, master = environment side (requesters and RAM).
interface mem_arbiter_if #(
  parameter int AW = 12
);
  logic          m0_req;
  logic          m0_we;
  logic [31:0]   m0_addr;
  logic [31:0]   m0_wdata;
  logic          m0_ack;
  logic [31:0]   m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [31:0]   m1_addr;
  logic [31:0]   m1_wdata;
  logic          m1_ack;
  logic [31:0]   m1_rdata;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_rdata,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter serialising accesses to one synchronous RAM (IDLE -> ACC -> RESP).
// Define MEM_ARBITER_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
module mem_arbiter #(
  parameter int AW = 12
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic          owner_reg, owner_next;          // 0 = port 0, 1 = port 1
  logic          we_reg, we_next;
  logic          in_range_reg, in_range_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [31:0]   wdata_reg, wdata_next;
  logic          m0_ack_reg, m0_ack_next;
  logic          m1_ack_reg, m1_ack_next;
  logic [31:0]   m0_rdata_reg, m0_rdata_next;
  logic [31:0]   m1_rdata_reg, m1_rdata_next;

  logic          any_req;
  logic          winner;
  logic          sel_we;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic [31:0]   resp_data;
  logic          unused_addr_bits;

  assign any_req = bus.m0_req | bus.m1_req;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
  assign winner = ~bus.m0_req;
`else
  logic last_reg, last_next;                     // port served by the most recent grant

  // On a tie the port that was not served last wins.
  assign winner = (bus.m0_req && bus.m1_req) ? ~last_reg : ~bus.m0_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg <= 1'b1;
    end else begin
      last_reg <= last_next;
    end
  end

  always_comb begin
    last_next = last_reg;
    if (state_reg == IDLE && any_req) begin
      last_next = winner;
    end
  end
`endif

  assign sel_we    = winner ? bus.m1_we    : bus.m0_we;
  assign sel_addr  = winner ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = winner ? bus.m1_wdata : bus.m0_wdata;
  assign unused_addr_bits = ^sel_addr[1:0];

  // Writes and out-of-range reads return zero.
  assign resp_data = (we_reg || !in_range_reg) ? 32'd0 : bus.ram_rdata;

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    we_next       = we_reg;
    in_range_next = in_range_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    m0_ack_next   = 1'b0;
    m1_ack_next   = 1'b0;
    m0_rdata_next = 32'd0;
    m1_rdata_next = 32'd0;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next    = ACC;
          owner_next    = winner;
          we_next       = sel_we;
          in_range_next = (sel_addr[31:AW+2] == '0);
          addr_next     = sel_addr[AW+1:2];
          wdata_next    = sel_wdata;
        end
      end
      ACC: begin
        state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
        if (owner_reg) begin
          m1_ack_next   = 1'b1;
          m1_rdata_next = resp_data;
        end else begin
          m0_ack_next   = 1'b1;
          m0_rdata_next = resp_data;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      owner_reg    <= 1'b0;
      we_reg       <= 1'b0;
      in_range_reg <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= 32'd0;
      m0_ack_reg   <= 1'b0;
      m1_ack_reg   <= 1'b0;
      m0_rdata_reg <= 32'd0;
      m1_rdata_reg <= 32'd0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      we_reg       <= we_next;
      in_range_reg <= in_range_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      m0_ack_reg   <= m0_ack_next;
      m1_ack_reg   <= m1_ack_next;
      m0_rdata_reg <= m0_rdata_next;
      m1_rdata_reg <= m1_rdata_next;
    end
  end

  assign bus.m0_ack    = m0_ack_reg;
  assign bus.m1_ack    = m1_ack_reg;
  assign bus.m0_rdata  = m0_rdata_reg;
  assign bus.m1_rdata  = m1_rdata_reg;
  assign bus.ram_addr  = addr_reg;
  assign bus.ram_wdata = wdata_reg;
  // Gated by rst so a reset landing in ACC cannot commit the write at that same edge.
  assign bus.ram_we    = (state_reg == ACC) && we_reg && in_range_reg && !rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random two-port
// traffic, checked against a transaction-level memory and arbitration model.
module tb_mem_arbiter;
  localparam int AW = 12;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  mem_arbiter_if #(.AW(AW)) bus ();
  mem_arbiter #(.AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [31:0]   ram_mem [0:(1<<AW)-1] = '{default: '0};
  logic [31:0]   ref_mem [0:(1<<AW)-1] = '{default: '0};
  int            n_vec = 0;
  int            n_err = 0;
  int            we_cnt = 0;
  int            ack0_cnt = 0;
  int            ack1_cnt = 0;
  logic [AW-1:0] last_waddr = '0;
  logic [31:0]   last_wdata = '0;
  int            model_last;
  int            c_order [8];
  int            c_tks [8];
  int            c_nacks;
  int            e_order [8];

  // Synchronous RAM plus event counters.
  always @(posedge clk) begin
    if (bus.ram_we) begin
      ram_mem[bus.ram_addr] <= bus.ram_wdata;
      we_cnt     <= we_cnt + 1;
      last_waddr <= bus.ram_addr;
      last_wdata <= bus.ram_wdata;
    end
    bus.ram_rdata <= ram_mem[bus.ram_addr];
    if (bus.m0_ack) ack0_cnt <= ack0_cnt + 1;
    if (bus.m1_ack) ack1_cnt <= ack1_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag, input string obs, input string exp);
    n_vec++;
    n_err++;
    $error("FAIL %s: observed %s expected %s", tag, obs, exp);
  endtask

  // Memory model: word-addressed, out-of-range writes dropped and reads give zero.
  function automatic logic [31:0] model_access(input logic we, input logic [31:0] addr,
                                               input logic [31:0] wdata);
    int idx;
    if ((addr >> (AW + 2)) != 0) return 32'd0;
    idx = int'((addr >> 2) & ((32'd1 << AW) - 1));
    if (we) begin
      ref_mem[idx] = wdata;
      return 32'd0;
    end
    return ref_mem[idx];
  endfunction

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end
  endtask

  function automatic logic ack_of(input int p);
    return (p == 0) ? bus.m0_ack : bus.m1_ack;
  endfunction

  function automatic logic [31:0] rdata_of(input int p);
    return (p == 0) ? bus.m0_rdata : bus.m1_rdata;
  endfunction

  // Single access on one port; lat = edges from the first sampling edge to the ack edge.
  task automatic access(input int p, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
    lat   = -1;
    rdata = 32'd0;
    drive(p, 1'b1, we, addr, wdata);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ack_of(p)) begin
        lat   = k - 1;
        rdata = rdata_of(p);
        break;
      end
    end
    drive(p, 1'b0, 1'b0, 32'd0, 32'd0);
    model_last = p;
    if (lat < 0) fail_now($sformatf("access_p%0d", p), "timeout", "ack");
  endtask

  // Grant order from the arbitration rule, one grant slot per access; m1 present from slot s1.
  task automatic predict(input int n0, input int n1, input int s1);
    int r0, r1, w;
    r0 = n0;
    r1 = n1;
    for (int s = 0; s < 8; s++) e_order[s] = -1;
    for (int s = 0; s < n0 + n1; s++) begin
      if (r0 > 0 && r1 > 0 && s >= s1) w = FIXED ? 0 : ((model_last == 0) ? 1 : 0);
      else w = (r0 > 0) ? 0 : 1;
      e_order[s] = w;
      model_last = w;
      if (w == 0) r0--; else r1--;
    end
  endtask

  // Both ports read repeatedly, holding req until their count is used up.
  task automatic contend(input int n0, input int n1, input int d1,
                         input logic [31:0] a0, input logic [31:0] a1);
    int          rem [2];
    logic [31:0] ad [2];
    rem[0] = n0; rem[1] = n1; ad[0] = a0; ad[1] = a1;
    c_nacks = 0;
    for (int i = 0; i < 8; i++) begin c_order[i] = -1; c_tks[i] = -1; end
    if (n0 > 0) drive(0, 1'b1, 1'b0, a0, 32'd0);
    if (n1 > 0 && d1 == 0) drive(1, 1'b1, 1'b0, a1, 32'd0);
    for (int t = 1; t <= 100 && c_nacks < n0 + n1; t++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        if (ack_of(p)) begin
          if (rem[p] == 0 || c_nacks >= 8) begin
            fail_now($sformatf("contend_extra_ack_p%0d", p), "ack", "no ack");
          end else begin
            check($sformatf("contend_rdata_p%0d", p), rdata_of(p), model_access(1'b0, ad[p], 32'd0));
            c_order[c_nacks] = p;
            c_tks[c_nacks]   = t;
            c_nacks++;
            rem[p]--;
            if (rem[p] == 0) drive(p, 1'b0, 1'b0, 32'd0, 32'd0);
          end
        end
      end
      if (n1 > 0 && d1 > 0 && t == d1) drive(1, 1'b1, 1'b0, a1, 32'd0);
    end
    if (c_nacks != n0 + n1) fail_now("contend", "timeout", "all acks");
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic check_contend(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_order%0d", tag, i), 64'(c_order[i]), 64'(e_order[i]));
      check($sformatf("%s_tick%0d", tag, i), 64'(c_tks[i]), 64'(3 * (i + 1)));
    end
  endtask

  initial begin
    logic [31:0] rd, exp_rd;
    int          lat, w0, a0, a1;
    int          pend [2], wt [2];
    logic        rwe [2];
    logic [31:0] raddr [2], rwd [2];

    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);

    // Power-on reset.
    rst = 1'b1;
    repeat (3) tick();
    check("rst_m0_ack", bus.m0_ack, 1'b0);
    check("rst_m1_ack", bus.m1_ack, 1'b0);
    check("rst_m0_rdata", bus.m0_rdata, 32'd0);
    check("rst_m1_rdata", bus.m1_rdata, 32'd0);
    check("rst_ram_we", bus.ram_we, 1'b0);
    check("rst_ram_addr", bus.ram_addr, '0);
    check("rst_ram_wdata", bus.ram_wdata, 32'd0);
    rst = 1'b0;
    model_last = 1;
    tick();

    // Write then read back on port 0.
    w0 = we_cnt;
    exp_rd = model_access(1'b1, 32'h10, 32'hDEADBEEF);
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, lat);
    check("wr_latency", 64'(lat), 64'd2);
    check("wr_rdata", rd, exp_rd);
    check("wr_strobes", 64'(we_cnt - w0), 64'd1);
    check("wr_ram_addr", last_waddr, AW'(4));
    check("wr_ram_wdata", last_wdata, 32'hDEADBEEF);
    exp_rd = model_access(1'b0, 32'h10, 32'd0);
    access(0, 1'b0, 32'h10, 32'd0, rd, lat);
    check("rd_latency", 64'(lat), 64'd2);
    check("rd_rdata", rd, exp_rd);
    exp_rd = model_access(1'b1, 32'h20, 32'hA5A5_0020);
    access(1, 1'b1, 32'h20, 32'hA5A5_0020, rd, lat);
    check("m1_wr_latency", 64'(lat), 64'd2);
    check("m1_wr_rdata", rd, exp_rd);

    // Out-of-range write is dropped, out-of-range read returns zero.
    w0 = we_cnt;
    exp_rd = model_access(1'b1, 32'h0001_0000, 32'h1234_5678);
    access(1, 1'b1, 32'h0001_0000, 32'h1234_5678, rd, lat);
    check("oor_wr_latency", 64'(lat), 64'd2);
    check("oor_wr_strobes", 64'(we_cnt - w0), 64'd0);
    exp_rd = model_access(1'b0, 32'h0001_0000, 32'd0);
    access(1, 1'b0, 32'h0001_0000, 32'd0, rd, lat);
    check("oor_rd_rdata", rd, exp_rd);
    exp_rd = model_access(1'b0, 32'h0, 32'd0);
    access(0, 1'b0, 32'h0, 32'd0, rd, lat);
    check("oor_alias_word0", rd, exp_rd);

    // Reset while a write is in ACC aborts it.
    exp_rd = model_access(1'b1, 32'h30, 32'h1111_1111);
    access(0, 1'b1, 32'h30, 32'h1111_1111, rd, lat);
    w0 = we_cnt;
    drive(0, 1'b1, 1'b1, 32'h30, 32'h2222_2222);
    tick();
    check("acc_ram_we", bus.ram_we, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_ram_we_now", bus.ram_we, 1'b0);
    tick();
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b0;
    model_last = 1;
    check("abort_ram_addr", bus.ram_addr, '0);
    check("abort_ram_wdata", bus.ram_wdata, 32'd0);
    check("abort_ram_we", bus.ram_we, 1'b0);
    a0 = ack0_cnt;
    repeat (4) tick();
    check("abort_no_ack", 64'(ack0_cnt - a0), 64'd0);
    check("abort_no_strobe", 64'(we_cnt - w0), 64'd0);
    exp_rd = model_access(1'b0, 32'h30, 32'd0);
    access(0, 1'b0, 32'h30, 32'd0, rd, lat);
    check("abort_readback", rd, exp_rd);

    // Ties straight after reset, then repeated ties with both ports holding req.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_last = 1;
    predict(1, 1, 0);
    contend(1, 1, 0, 32'h10, 32'h20);
    check_contend("tie1", 2);
    predict(2, 2, 0);
    contend(2, 2, 0, 32'h10, 32'h20);
    check_contend("tie2", 4);

    // Port 0 streams four accesses while port 1 asks once.
    predict(4, 1, 1);
    contend(4, 1, 1, 32'h10, 32'h20);
    check_contend("stream", 5);

    // One-cycle port 1 pulse during a port 0 access is ignored.
    w0 = we_cnt;
    a1 = ack1_cnt;
    drive(0, 1'b1, 1'b0, 32'h10, 32'd0);
    tick();
    drive(1, 1'b1, 1'b1, 32'h40, 32'hCAFE_F00D);
    tick();
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    check("pulse_m0_ack", bus.m0_ack, 1'b1);
    check("pulse_m0_rdata", bus.m0_rdata, model_access(1'b0, 32'h10, 32'd0));
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    model_last = 0;
    repeat (5) tick();
    check("pulse_no_m1_ack", 64'(ack1_cnt - a1), 64'd0);
    check("pulse_no_strobe", 64'(we_cnt - w0), 64'd0);
    exp_rd = model_access(1'b0, 32'h40, 32'd0);
    access(0, 1'b0, 32'h40, 32'd0, rd, lat);
    check("pulse_readback", rd, exp_rd);

    // Random two-port traffic.
    pend[0] = 0; pend[1] = 0; wt[0] = 0; wt[1] = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc >= 400 && pend[0] == 0 && pend[1] == 0) break;
      tick();
      for (int p = 0; p < 2; p++) begin
        if (pend[p] != 0) begin
          wt[p]++;
          if (ack_of(p)) begin
            check($sformatf("rnd_rdata_p%0d", p), rdata_of(p), model_access(rwe[p], raddr[p], rwd[p]));
            if (p == 0 || !FIXED) check($sformatf("rnd_wait_p%0d_%0d", p, wt[p]), 64'(wt[p] <= 6), 64'd1);
            pend[p] = 0;
            drive(p, 1'b0, 1'b0, 32'd0, 32'd0);
          end else begin
            check($sformatf("rnd_wait_rdata_p%0d", p), rdata_of(p), 32'd0);
            if (wt[p] > 300) begin
              fail_now($sformatf("rnd_p%0d", p), "timeout", "ack");
              pend[p] = 0;
              drive(p, 1'b0, 1'b0, 32'd0, 32'd0);
            end
          end
        end else begin
          check($sformatf("rnd_idle_p%0d", p), {ack_of(p), rdata_of(p)}, 33'd0);
        end
        if (pend[p] == 0 && cyc < 400 && $urandom_range(0, 2) == 0) begin
          rwe[p]   = 1'($urandom_range(0, 1));
          raddr[p] = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
          if ($urandom_range(0, 7) == 0) raddr[p] = raddr[p] | (32'd1 << $urandom_range(AW + 2, 31));
          rwd[p]   = $urandom;
          pend[p]  = 1;
          wt[p]    = 0;
          drive(p, 1'b1, rwe[p], raddr[p], rwd[p]);
        end
      end
    end
    if (pend[0] != 0 || pend[1] != 0) fail_now("rnd_drain", "pending", "idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
